// File: rtl/sys_defs.sv
// Shared fetch/decode definitions: instruction-buffer entry and the
// multi-lane packets exchanged with fetch and decode.
package sys_defs;

    localparam int FETCH_WIDTH  = 2;
    localparam int DECODE_WIDTH = 2;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] npc;
        logic        valid;
    } IB_ENTRY;

    typedef struct packed {
        IB_ENTRY [FETCH_WIDTH-1:0]           entry;
        logic [$clog2(FETCH_WIDTH+1)-1:0]    count;
    } IF_IB_PACKET;

    typedef struct packed {
        IB_ENTRY [DECODE_WIDTH-1:0]          entry;
        logic [DECODE_WIDTH-1:0]             valid;
    } IB_ID_PACKET;

endpackage

// File: rtl/ib_mp_ram.sv
// Multi-port entry storage: WR_WIDTH write lanes and RD_WIDTH combinational
// read lanes, each lane addressed at base+lane modulo DEPTH. Not reset.
module ib_mp_ram
    import sys_defs::*;
#(
    parameter int DEPTH    = 16,
    parameter int WR_WIDTH = 2,
    parameter int RD_WIDTH = 2
)
(
    input  logic                         i_clk,
    input  logic [WR_WIDTH-1:0]          i_wr_en,
    input  logic [$clog2(DEPTH)-1:0]     i_wr_base,
    input  IB_ENTRY [WR_WIDTH-1:0]       i_wr_data,
    input  logic [$clog2(DEPTH)-1:0]     i_rd_base,
    output IB_ENTRY [RD_WIDTH-1:0]       o_rd_data
);

    localparam int PW = $clog2(DEPTH);

    IB_ENTRY r_mem [DEPTH];

    // Pointer-width addition wraps naturally, giving the modulo addressing.
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < WR_WIDTH; k++) begin
            if (i_wr_en[k]) begin
                r_mem[i_wr_base + PW'(k)] <= i_wr_data[k];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < RD_WIDTH; i++) begin
            o_rd_data[i] = r_mem[i_rd_base + PW'(i)];
        end
    end

endmodule

// File: rtl/inst_buffer_mp.sv
// Multi-ported FWFT instruction buffer between fetch and decode, with
// occupancy/free-slot outputs and single-cycle squash.
module inst_buffer_mp
    import sys_defs::*;
#(
    parameter int DEPTH      = 16,
    parameter int WR_WIDTH   = 2,
    parameter int RD_WIDTH   = 2,
    parameter bit CHECK_TAKE = 1'b1
)
(
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              squash,
    input  IB_ENTRY [WR_WIDTH-1:0]            in_entry,
    input  logic [$clog2(WR_WIDTH+1)-1:0]     in_count,
    output logic                              in_ready,
    output IB_ENTRY [RD_WIDTH-1:0]            out_entry,
    output logic [RD_WIDTH-1:0]               out_valid,
    input  logic [$clog2(RD_WIDTH+1)-1:0]     out_take,
    output logic [$clog2(DEPTH):0]            count,
    output logic [$clog2(DEPTH):0]            free_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]       r_head;
    logic [PW-1:0]       r_tail;
    logic [CW-1:0]       r_cnt;

    logic [CW-1:0]       w_free;
    logic [CW-1:0]       w_in_n;
    logic [CW-1:0]       w_wr_n;
    logic [CW-1:0]       w_nvalid;
    logic [CW-1:0]       w_take;
    logic [CW-1:0]       w_rd_n;
    logic [WR_WIDTH-1:0] w_wr_en;

    // Accept only full-group capacity from current occupancy; reads this
    // cycle are not credited, which keeps in_ready off the decode path.
    always_comb begin
        w_free   = CW'(DEPTH) - r_cnt;
        in_ready = (w_free >= CW'(WR_WIDTH)) && !squash;
        w_in_n   = (CW'(in_count) > CW'(WR_WIDTH)) ? CW'(WR_WIDTH) : CW'(in_count);
        w_wr_n   = in_ready ? w_in_n : '0;
        w_nvalid = (r_cnt > CW'(RD_WIDTH)) ? CW'(RD_WIDTH) : r_cnt;
        w_take   = CW'(out_take);
        w_rd_n   = squash ? '0 : ((w_take > w_nvalid) ? w_nvalid : w_take);
        w_wr_en  = '0;
        for (int k = 0; k < WR_WIDTH; k++) begin
            w_wr_en[k] = reset && (CW'(k) < w_wr_n);
        end
        out_valid = '0;
        for (int i = 0; i < RD_WIDTH; i++) begin
            out_valid[i] = (r_cnt > CW'(i)) && !squash;
        end
        count      = r_cnt;
        free_count = w_free;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= '0;
        end else if (squash) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= '0;
        end else begin
            r_head <= r_head + PW'(w_rd_n);
            r_tail <= r_tail + PW'(w_wr_n);
            r_cnt  <= r_cnt + w_wr_n - w_rd_n;
        end
    end

    ib_mp_ram #(
        .DEPTH    (DEPTH),
        .WR_WIDTH (WR_WIDTH),
        .RD_WIDTH (RD_WIDTH)
    ) u_ram (
        .i_clk     (clock),
        .i_wr_en   (w_wr_en),
        .i_wr_base (r_tail),
        .i_wr_data (in_entry),
        .i_rd_base (r_head),
        .o_rd_data (out_entry)
    );

    // Over-take is clamped above; decode asking for absent lanes is a protocol bug.
    generate
        if (CHECK_TAKE) begin : g_take_chk
            always_ff @(posedge clock) begin
                if (reset && !squash && (r_cnt != '0)) begin
                    assert (w_take <= w_nvalid);
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_inst_buffer_mp.sv
// Bench for inst_buffer_mp: vector table driven through a queue-based
// reference of buffer contents, plus a reset-mid-burst sequence.
module tb_inst_buffer_mp;
    import sys_defs::*;

    logic             clock;
    logic             reset;
    logic             squash;
    IB_ENTRY [1:0]    in_entry;
    logic [1:0]       in_count;
    logic             in_ready;
    IB_ENTRY [1:0]    out_entry;
    logic [1:0]       out_valid;
    logic [1:0]       out_take;
    logic [4:0]       count;
    logic [4:0]       free_count;

    int tests;
    int fails;
    logic [31:0] pc_next;
    IB_ENTRY sb[$];

    typedef struct {
        int nin;
        int take;
        bit sq;
        int cnt;
        bit rdy;
    } vec_t;
    vec_t vecs[$];

    inst_buffer_mp #(
        .DEPTH      (16),
        .WR_WIDTH   (2),
        .RD_WIDTH   (2),
        .CHECK_TAKE (1'b0)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .squash     (squash),
        .in_entry   (in_entry),
        .in_count   (in_count),
        .in_ready   (in_ready),
        .out_entry  (out_entry),
        .out_valid  (out_valid),
        .out_take   (out_take),
        .count      (count),
        .free_count (free_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic IB_ENTRY mk(input logic [31:0] pc);
        IB_ENTRY e;
        e.inst  = pc ^ 32'hDEAD_0000;
        e.pc    = pc;
        e.npc   = pc + 32'd4;
        e.valid = 1'b1;
        return e;
    endfunction

    function automatic void add(input int nin, input int take, input bit sq,
                                input int cnt, input bit rdy);
        vec_t v;
        v.nin = nin; v.take = take; v.sq = sq; v.cnt = cnt; v.rdy = rdy;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one edge, drive a new input set, check combinational view
    // against the reference queue, then update the reference.
    task automatic step(input int nin, input int take, input bit sq);
        int  nvalid;
        int  rd;
        int  sz;
        bit  rdy;
        @(posedge clock);
        #1;
        for (int k = 0; k < 2; k++) in_entry[k] = mk(pc_next + 32'(4 * k));
        in_count = 2'(nin);
        out_take = 2'(take);
        squash   = sq;
        #1;
        sz     = sb.size();
        rdy    = ((16 - sz) >= 2) && !sq;
        nvalid = sq ? 0 : ((sz < 2) ? sz : 2);
        check("in_ready", 128'(in_ready), 128'(rdy));
        check("count", 128'(count), 128'(sz));
        check("free_count", 128'(free_count), 128'(16 - sz));
        for (int i = 0; i < 2; i++) begin
            check("out_valid", 128'(out_valid[i]), 128'(i < nvalid));
            if (i < nvalid) check("out_entry", 128'(out_entry[i]), 128'(sb[i]));
        end
        if (sq) begin
            sb.delete();
        end else begin
            rd = (take < nvalid) ? take : nvalid;
            repeat (rd) void'(sb.pop_front());
            if (rdy) begin
                for (int k = 0; k < nin; k++) sb.push_back(mk(pc_next + 32'(4 * k)));
                pc_next = pc_next + 32'(4 * nin);
            end
        end
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        pc_next  = 32'h0;
        reset    = 1'b0;
        squash   = 1'b0;
        in_count = '0;
        out_take = '0;
        in_entry = '0;

        // reset view, fill to full, dropped group, ordered drain, empty take
        add(0, 0, 0, 0, 1);
        for (int k = 0; k < 8; k++) add(2, 0, 0, 2 * k, 1);
        add(2, 0, 0, 16, 0);
        add(0, 0, 0, 16, 0);
        for (int k = 0; k < 8; k++) add(0, 2, 0, 16 - 2 * k, (k != 0));
        add(0, 2, 0, 0, 1);
        // move head to index 15
        for (int k = 0; k < 7; k++) add(2, 0, 0, 2 * k, 1);
        add(1, 0, 0, 14, 1);
        for (int k = 0; k < 7; k++) add(0, 2, 0, 15 - 2 * k, (k != 0));
        add(0, 1, 0, 1, 1);
        // wrapped fill, simultaneous read/write across the wrap, drain
        for (int k = 0; k < 7; k++) add(2, 0, 0, 2 * k, 1);
        add(2, 2, 0, 14, 1);
        for (int k = 0; k < 7; k++) add(0, 2, 0, 14 - 2 * k, 1);
        add(0, 0, 0, 0, 1);
        // squash with pending write and read at count 9
        for (int k = 0; k < 4; k++) add(2, 0, 0, 2 * k, 1);
        add(1, 0, 0, 8, 1);
        add(2, 2, 1, 9, 0);
        add(0, 0, 0, 0, 1);
        // over-take clamp
        add(1, 0, 0, 0, 1);
        add(0, 2, 0, 1, 1);
        add(0, 0, 0, 0, 1);

        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].nin, vecs[i].take, vecs[i].sq);
            check("tbl_count", 128'(count), 128'(vecs[i].cnt));
            check("tbl_in_ready", 128'(in_ready), 128'(vecs[i].rdy));
        end

        // reset asserted while a write group is pending
        step(2, 0, 0);
        @(posedge clock);
        #1;
        for (int k = 0; k < 2; k++) in_entry[k] = mk(pc_next + 32'(4 * k));
        in_count = 2'd2;
        reset    = 1'b0;
        @(posedge clock);
        #1;
        reset    = 1'b1;
        in_count = '0;
        sb.delete();
        #1;
        check("rst_count", 128'(count), 128'(0));
        check("rst_valid", 128'(out_valid), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_free", 128'(free_count), 128'(16));
        step(0, 0, 0);
        step(0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
